// File: rtl/tx_pkg.sv
// Shared types and constants for the UART transmit buffer.
// TX_PARITY_EN (see tx_buffer) adds an even-parity bit to each frame.
package tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO feeding the transmitter; full/empty come from the registered count.
// Writes while full are dropped even if a pop happens on the same edge.
module tx_fifo
  import tx_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_BITS-1:0] din,
  output logic [DATA_BITS-1:0] dout,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 empty
);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 wr;
  logic                 rd;

  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr, rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tx_buffer.sv
// Queued UART transmitter, 8N1 LSB first, idle-high line.
// Define TX_PARITY_EN to insert an even-parity bit before the stop bit.
module tx_buffer
  import tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100,
  parameter int DEPTH        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] tx_byte,
  output logic       tx_serial,
  output logic       busy,
  output logic       full,
  output logic       tx_done
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  state_t               state;
  state_t               state_nxt;
  logic [CW-1:0]        clk_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] head;
  logic [$clog2(DEPTH):0] count;
  logic                 empty;
  logic                 pop;
  logic                 tick;
`ifdef TX_PARITY_EN
  logic                 parity_q;
`endif

  tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (send),
    .pop  (pop),
    .din  (tx_byte),
    .dout (head),
    .count(count),
    .full (full),
    .empty(empty)
  );

  assign pop     = (state == IDLE) && (count != '0);
  assign busy    = state != IDLE;
  assign tx_done = (state == STOP) && tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
`ifdef TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE || tick) clk_cnt <= '0;
      else                       clk_cnt <= clk_cnt + CW'(1);
      if (pop) begin
        shift   <= head;
        bit_cnt <= '0;
`ifdef TX_PARITY_EN
        parity_q <= ^head;
`endif
      end else if (state == DATA && tick) begin
        shift   <= shift >> 1;
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Line level is decoded from state so a reset forces it high at once
  always_comb begin
    state_nxt = state;
    tx_serial = IDLE_LEVEL;
    tick      = clk_cnt == LAST_CLK;
    unique case (state)
      IDLE: begin
        if (!empty) state_nxt = START;
      end
      START: begin
        tx_serial = 1'b0;
        if (tick) state_nxt = DATA;
      end
      DATA: begin
        tx_serial = shift[0];
        if (tick && bit_cnt == LAST_BIT) begin
`ifdef TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
      PARITY: begin
`ifdef TX_PARITY_EN
        tx_serial = parity_q;
        if (tick) state_nxt = STOP;
`else
        state_nxt = IDLE;
`endif
      end
      STOP: begin
        if (tick) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tx_buffer.sv
// Bench for tx_buffer: frame tables, corner sequences and random traffic
// checked against a queue-and-waveform model of the transmitter.
module tb_tx_buffer;

  localparam int C = 4;
  localparam int D = 4;
`ifdef TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * C;

  logic       clk = 1'b0;
  logic       rst;
  logic       send;
  logic [7:0] tx_byte;
  logic       tx_serial;
  logic       busy;
  logic       full;
  logic       tx_done;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  byte unsigned q[$];
  bit           wave[$];
  int           pos = -1;

  typedef struct {
    logic [7:0] b;
    logic [9:0] line;
    logic       par;
  } vec_t;

  vec_t vecs[8];

  tx_buffer #(.CLKS_PER_BIT(C), .DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .send     (send),
    .tx_byte  (tx_byte),
    .tx_serial(tx_serial),
    .busy     (busy),
    .full     (full),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    wave.delete();
    pos = -1;
  endtask

  // One clock edge of the reference: frame waveform built from the byte
  task automatic model_edge(bit s, logic [7:0] b);
    bit           was_full;
    byte unsigned v;
    if (rst) begin
      model_reset();
      return;
    end
    was_full = q.size() == D;
    if (pos >= 0) begin
      pos++;
      if (pos == FRAME) pos = -1;
    end else if (q.size() != 0) begin
      v = q.pop_front();
      wave.delete();
      repeat (C) wave.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (C) wave.push_back(v[i]);
`ifdef TX_PARITY_EN
      repeat (C) wave.push_back(^v);
`endif
      repeat (C) wave.push_back(1'b1);
      pos = 0;
    end
    if (s && !was_full) q.push_back(b);
  endtask

  task automatic compare_model();
    check("tx_serial", tx_serial, pos < 0 ? 1'b1 : wave[pos]);
    check("busy", busy, pos >= 0);
    check("full", full, q.size() == D);
    check("tx_done", tx_done, pos == FRAME - 1);
  endtask

  task automatic step(bit s, logic [7:0] b);
    send    = s;
    tx_byte = b;
    @(posedge clk);
    model_edge(s, b);
    #1;
    compare_model();
    done_cnt += int'(tx_done);
  endtask

  initial begin
    logic [10:0] e;
    int          d0;
    byte unsigned seq[5];

    vecs[0] = '{8'h41, 10'b1010000010, 1'b0};
    vecs[1] = '{8'h55, 10'b1010101010, 1'b0};
    vecs[2] = '{8'h00, 10'b1000000000, 1'b0};
    vecs[3] = '{8'hFF, 10'b1111111110, 1'b0};
    vecs[4] = '{8'hA3, 10'b1101000110, 1'b0};
    vecs[5] = '{8'h07, 10'b1000001110, 1'b1};
    vecs[6] = '{8'h03, 10'b1000000110, 1'b0};
    vecs[7] = '{8'h80, 10'b1100000000, 1'b1};
    seq = '{8'h48, 8'h41, 8'h4E, 8'h47, 8'h4D};

    // Reset held with a send request pending
    rst = 1'b0;
    send = 1'b1;
    tx_byte = 8'h41;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("rst_async_line", tx_serial, 1'b1);
    check("rst_async_busy", busy, 1'b0);
    repeat (2) begin
      @(posedge clk);
      model_edge(1'b1, 8'h41);
      #1;
      compare_model();
      check("rst_done", tx_done, 1'b0);
    end
    rst = 1'b0;
    repeat (50) step(1'b0, 8'h00);

    // Frame shapes from the table
    foreach (vecs[t]) begin
`ifdef TX_PARITY_EN
      e = {vecs[t].line[9], vecs[t].par, vecs[t].line[8:0]};
`else
      e = {1'b1, vecs[t].line};
`endif
      step(1'b1, vecs[t].b);
      for (int k = 0; k < FRAME; k++) begin
        step(1'b0, 8'h00);
        check("table_line", tx_serial, e[k / C]);
        check("table_busy", busy, 1'b1);
        check("table_done", tx_done, k == FRAME - 1);
      end
      step(1'b0, 8'h00);
      check("table_idle", busy, 1'b0);
    end

    // Reset during data bit 3 of 8'h55 with two bytes queued
    step(1'b1, 8'h55);
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    for (int g = 0; g < 100 && pos != C * 4 + 1; g++) step(1'b0, 8'h00);
    check_int("mid_reached", pos, C * 4 + 1);
    check("mid_pre_line", tx_serial, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("mid_rst_line", tx_serial, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_full", full, 1'b0);
    repeat (2) step(1'b0, 8'h00);
    rst = 1'b0;
    repeat (60) step(1'b0, 8'h00);

    // Back-to-back fill, then overflow pushes until the pop edge
    d0 = done_cnt;
    foreach (seq[i]) step(1'b1, seq[i]);
    check("b2b_full", full, 1'b1);
    for (int g = 0; g < 200 && q.size() == D; g++) step(1'b1, 8'hFF);
    check("ovf_released", full, 1'b0);
    repeat (6 * FRAME) step(1'b0, 8'h00);
    check_int("b2b_frames", done_cnt - d0, 5);

    // Random traffic with occasional resets
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 1499) == 0) begin
        rst = 1'b1;
        step(1'b0, 8'h00);
        rst = 1'b0;
      end
      step($urandom_range(0, 11) == 0, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_buffer.md
Name: tx_buffer

Overview:
Transmit-side counterpart to the receive buffer. It accepts guess/status bytes from the game logic and queues them in a small FIFO. Each byte is serialized onto the UART line as an 8N1 frame, LSB first. It sits between the game FSM and the wireless module's serial input.

Parameters:
CLKS_PER_BIT, 100, clock cycles per UART bit period (≥2)
DEPTH, 4, FIFO entries (power of two, ≥2)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
send  input  1  request to enqueue tx_byte; sampled every rising edge
tx_byte  input  8  byte to enqueue; valid when send=1
tx_serial  output  1  UART line, idle high
busy  output  1  high while a frame is on the line (states START..STOP)
full  output  1  FIFO holds DEPTH entries
tx_done  output  1  one-cycle pulse on the last cycle of a STOP bit

Behaviour:
- Reset (async assert, sync release): tx_serial=1, busy=0, full=0, tx_done=0, FIFO count=0, state=IDLE, bit/clock counters=0.
- Reset mid-frame: line returns high immediately. Frame is aborted. Queued bytes are discarded.
- Enqueue: on an edge with send=1 and full=0, tx_byte is written and count increments.
  - send=1 while full=1: byte silently dropped, no state change.
  - full is derived from the registered count. There is no same-cycle pass-through: a pop on the same edge does not allow a write when full=1.
- Simultaneous push+pop (not full): count unchanged, both operations performed.
- Pointers wrap modulo DEPTH. count width is clog2(DEPTH)+1.
- FSM states IDLE, START, DATA, STOP (plus PARITY, optional).
  - IDLE: tx_serial=1, busy=0. If count≠0 at an edge: pop head into 8-bit shift register, go to START.
  - START: tx_serial=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx_serial=shift[0]. After CLKS_PER_BIT cycles shift right; repeat 8 bits, then STOP.
  - STOP: tx_serial=1 for CLKS_PER_BIT cycles. tx_done=1 on its final cycle. Then IDLE.
- Latency: a byte pushed at edge N into an empty FIFO with FSM in IDLE is popped at edge N+1. tx_serial falls in the cycle after edge N+1.
- Frame = 10×CLKS_PER_BIT cycles. Back-to-back frames are separated by exactly one IDLE cycle.
- The clock counter counts 0..CLKS_PER_BIT-1 and wraps.
- send during a frame is legal and only affects the FIFO.

Optional Feature:
Macro TX_PARITY_EN.
- Defined: PARITY state between DATA and STOP drives the even parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame = 11×CLKS_PER_BIT cycles.
- Undefined: no PARITY state; 8N1 only.

Decomposition:
- Package tx_pkg: state enum typedef (IDLE, START, DATA, PARITY, STOP), DATA_BITS=8, IDLE_LEVEL=1'b1.
- Sub-module tx_fifo (clk, rst, push, pop, din, dout, count, full, empty). It holds the storage and pointers.
- tx_buffer keeps the FSM, counters and shift register.

Test Plan:
- Reset: assert rst for 2 cycles with send=1, tx_byte=8'h41 -> tx_serial=1, busy=0, full=0, tx_done=0 throughout; nothing transmitted after release.
- Single byte, CLKS_PER_BIT=4: push 8'h41 -> line reads 0,1,0,0,0,0,0,1,0,1 (start, LSB-first data, stop), each held 4 cycles; tx_done pulses once on cycle 40 of the frame; busy high 40 cycles.
- Back-to-back: push 8'h48, 8'h41, 8'h4E, 8'h47, 8'h4D on 5 consecutive edges -> first popped immediately, next 4 fill FIFO and full=1. Five frames sent in order with exactly one idle cycle between each.
- Overflow: fill FIFO while a frame is in flight, then push 8'hFF while full=1 (including on the pop edge) -> 8'hFF never appears on the line; count stays at DEPTH until the pop.
- Reset mid-frame: assert rst during DATA bit 3 of 8'h55 with 2 bytes queued -> tx_serial=1 same cycle; no further frames after release.
- TX_PARITY_EN defined: push 8'h07 -> parity bit 1 inserted before stop; push 8'h03 -> parity bit 0; frame length 44 cycles at CLKS_PER_BIT=4.
